// File: rtl/sd_cmd_engine_if.sv
// SD command-line engine bundle: sequencer handshake, status/response and
// the SD CMD/CLK pin signals. The engine takes the slave view; the
// sequencer/pad side (or a testbench) takes the master view.
interface sd_cmd_engine_if;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         crc_err;
  logic [127:0] resp;
  logic         sd_clk;
  logic         sd_cmd_out;
  logic         sd_cmd_oe;
  logic         sd_cmd_in;

  modport slave (
    input  cmd_start, cmd_index, cmd_arg, resp_type, sd_cmd_in,
    output busy, done, timeout, crc_err, resp, sd_clk, sd_cmd_out, sd_cmd_oe
  );

  modport master (
    output cmd_start, cmd_index, cmd_arg, resp_type, sd_cmd_in,
    input  busy, done, timeout, crc_err, resp, sd_clk, sd_cmd_out, sd_cmd_oe
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD/SDIO command-line engine: sends one 48-bit command with CRC7 on CMD,
// generates sd_clk, receives a 48/136-bit response and reports status.
// Optional macro SD_RESP_CRC_CHECK_EN enables response CRC7/end-bit
// checking; without it crc_err is tied low and the end bit is ignored.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for cmd_start, cmd released
// SEND   | shifting the 48-bit frame out on sd_clk falling edges
// WAIT   | looking for the response start bit, bounded by RESP_TIMEOUT
// RECV   | shifting the response in on sd_clk rising edges
// NRC    | NRC idle sd_clk cycles with cmd released
// DONE   | one-cycle done pulse, busy still high
module sd_cmd_engine #(
  parameter int CLK_DIV      = 2,
  parameter int RESP_TIMEOUT = 64,
  parameter int NRC          = 8
) (
  input logic            clk,
  input logic            rst,
  sd_cmd_engine_if.slave sd
);

  localparam logic [7:0]  DIV_LOAD      = 8'(CLK_DIV - 1);
  localparam logic [15:0] TX_BITS       = 16'd48;
  localparam logic [15:0] TO_LOAD       = 16'(RESP_TIMEOUT);
  localparam logic [15:0] NRC_LOAD      = 16'(NRC);
  // Bits still to come after the start bit has been seen.
  localparam logic [15:0] RX_SHORT_LEFT = 16'd47;
  localparam logic [15:0] RX_LONG_LEFT  = 16'd135;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_RECV, S_NRC, S_DONE
  } state_e;

  // CRC7 (x^7+x^3+1, init 0) over 40 bits, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [39:0] d;
    logic [6:0]  c;
    logic        fb;
    d = data;
    c = '0;
    for (int i = 0; i < 40; i++) begin
      fb = d[39] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
      d  = {d[38:0], 1'b0};
    end
    return c;
  endfunction

  state_e       state_q, state_d;
  logic [7:0]   div_cnt_q;
  logic         sd_clk_q;
  logic         fall_tick, rise_tick;
  logic [15:0]  timer_q, timer_d;
  logic [47:0]  tx_q, tx_d;
  logic [126:0] rx_q, rx_d;
  logic [127:0] rx_nxt;
  logic [1:0]   rtype_q, rtype_d;
  logic         cmd_out_q, cmd_out_d;
  logic         cmd_oe_q, cmd_oe_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         timeout_q, timeout_d;
  logic [127:0] resp_q, resp_d;
`ifdef SD_RESP_CRC_CHECK_EN
  logic         crc_err_q, crc_err_d;
`endif

  // Free-running divider; sd_clk toggles each time the down-counter hits zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      sd_clk_q  <= 1'b1;
    end else if (div_cnt_q == 8'd0) begin
      div_cnt_q <= DIV_LOAD;
      sd_clk_q  <= ~sd_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q - 8'd1;
    end
  end

  assign fall_tick = (div_cnt_q == 8'd0) &&  sd_clk_q;
  assign rise_tick = (div_cnt_q == 8'd0) && !sd_clk_q;

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rtype_q   <= '0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      resp_q    <= '0;
`ifdef SD_RESP_CRC_CHECK_EN
      crc_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rtype_q   <= rtype_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      resp_q    <= resp_d;
`ifdef SD_RESP_CRC_CHECK_EN
      crc_err_q <= crc_err_d;
`endif
    end
  end

  // Next-state logic: one shared down-counter serves as bit counter,
  // response timeout and NRC timer, since those phases never overlap.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rtype_d   = rtype_q;
    cmd_out_d = cmd_out_q;
    cmd_oe_d  = cmd_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    resp_d    = resp_q;
`ifdef SD_RESP_CRC_CHECK_EN
    crc_err_d = crc_err_q;
`endif
    rx_nxt    = {rx_q, sd.sd_cmd_in};

    case (state_q)
      S_IDLE: begin
        if (sd.cmd_start) begin
          tx_d      = {2'b01, sd.cmd_index, sd.cmd_arg,
                       crc7({2'b01, sd.cmd_index, sd.cmd_arg}), 1'b1};
          rtype_d   = sd.resp_type;
          timer_d   = TX_BITS;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
          crc_err_d = 1'b0;
`endif
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (fall_tick) begin
          if (timer_q != 16'd0) begin
            cmd_out_d = tx_q[47];
            cmd_oe_d  = 1'b1;
            tx_d      = {tx_q[46:0], 1'b0};
            timer_d   = timer_q - 16'd1;
          end else begin
            cmd_out_d = 1'b1;
            cmd_oe_d  = 1'b0;
            if (rtype_q == 2'd0) begin
              timer_d = NRC_LOAD;
              state_d = S_NRC;
            end else begin
              timer_d = TO_LOAD;
              state_d = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        if (rise_tick) begin
          if (!sd.sd_cmd_in) begin
            rx_d    = rx_nxt[126:0];
            timer_d = (rtype_q == 2'd3) ? RX_LONG_LEFT : RX_SHORT_LEFT;
            state_d = S_RECV;
          end else if (timer_q <= 16'd1) begin
            timeout_d = 1'b1;
            timer_d   = NRC_LOAD;
            state_d   = S_NRC;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end

      S_RECV: begin
        if (rise_tick) begin
          rx_d = rx_nxt[126:0];
          if (timer_q <= 16'd1) begin
            // rx_nxt now holds the whole response, last bit in bit 0.
            resp_d = (rtype_q == 2'd3) ? rx_nxt : {90'b0, rx_nxt[45:8]};
`ifdef SD_RESP_CRC_CHECK_EN
            crc_err_d = !rx_nxt[0] ||
                        ((rtype_q == 2'd1) && (crc7(rx_nxt[47:8]) != rx_nxt[7:1]));
`endif
            timer_d = NRC_LOAD;
            state_d = S_NRC;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end

      S_NRC: begin
        if (rise_tick) begin
          if (timer_q <= 16'd1) begin
            done_d  = 1'b1;
            timer_d = '0;
            state_d = S_DONE;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign sd.sd_clk     = sd_clk_q;
  assign sd.sd_cmd_out = cmd_out_q;
  assign sd.sd_cmd_oe  = cmd_oe_q;
  assign sd.busy       = busy_q;
  assign sd.done       = done_q;
  assign sd.timeout    = timeout_q;
  assign sd.resp       = resp_q;
`ifdef SD_RESP_CRC_CHECK_EN
  assign sd.crc_err    = crc_err_q;
`else
  assign sd.crc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: directed test-plan scenarios plus
// randomized commands/responses against a behavioural card/host model.
module tb_sd_cmd_engine;
  localparam int CLK_DIV      = 2;
  localparam int RESP_TIMEOUT = 64;
  localparam int NRC          = 8;
`ifdef SD_RESP_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   rise_cnt = 0;
  int   cap_n = 0;
  int   done_cnt = 0;
  logic [47:0]  cap = '0;
  logic [135:0] card_bits = '0;
  int   card_len = 48;
  int   card_delay = 0;
  logic [127:0] exp_resp = '0;
  event card_ev;

  sd_cmd_engine_if ifc();

  sd_cmd_engine #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT), .NRC(NRC))
    dut (.clk(clk), .rst(rst), .sd(ifc));

  always #5 clk = ~clk;

  always @(posedge ifc.sd_clk) rise_cnt++;

  // Card-side view of the host frame: sampled on sd_clk rising edges.
  always @(posedge ifc.sd_clk)
    if (ifc.sd_cmd_oe) begin
      cap = {cap[46:0], ifc.sd_cmd_out};
      cap_n++;
    end

  always @(negedge clk) if (ifc.done) done_cnt++;

  // Card responder: after the host releases cmd, wait card_delay falling
  // edges, then drive card_len bits MSB-first on falling edges.
  always begin
    @(card_ev);
    @(negedge ifc.sd_cmd_oe);
    #1;
    repeat (card_delay) @(negedge ifc.sd_clk);
    for (int i = card_len - 1; i >= 0; i--) begin
      @(negedge ifc.sd_clk);
      ifc.sd_cmd_in = card_bits[i];
    end
    @(negedge ifc.sd_clk);
    ifc.sd_cmd_in = 1'b1;
  end

  // CRC7 as the remainder of polynomial long division of data*x^7 by 0x89.
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] card_short(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b00, idx, arg, ref_crc7({2'b00, idx, arg}), 1'b1};
  endfunction

  function automatic logic ref_crc_err(input logic [1:0] rt, input logic [135:0] b);
    logic bad;
    bad = !b[0] || ((rt == 2'd1) && (ref_crc7(b[47:8]) != b[7:1]));
    return CRC_ON && bad;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".sd_clk"},  128'(ifc.sd_clk), 128'd1);
    check({tag, ".cmd_out"}, 128'(ifc.sd_cmd_out), 128'd1);
    check({tag, ".cmd_oe"},  128'(ifc.sd_cmd_oe), 128'd0);
    check({tag, ".busy"},    128'(ifc.busy), 128'd0);
    check({tag, ".done"},    128'(ifc.done), 128'd0);
    check({tag, ".timeout"}, 128'(ifc.timeout), 128'd0);
    check({tag, ".crc_err"}, 128'(ifc.crc_err), 128'd0);
    check({tag, ".resp"},    ifc.resp, 128'd0);
  endtask

  // One full transaction from cmd_start to done, checked end to end.
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input bit respond, input logic [135:0] bits,
                         input int delay, input logic [47:0] exp_frame, input bit poke);
    int   cap0, rel_rise, to_rise, n, len, exp_lat;
    bit   seen_oe, released, got_done;
    logic exp_to, exp_ce;
    len     = (rt == 2'd3) ? 136 : 48;
    exp_to  = (rt != 2'd0) && !respond;
    exp_ce  = (rt != 2'd0) && respond && ref_crc_err(rt, bits);
    if (rt == 2'd0)    exp_lat = NRC;
    else if (!respond) exp_lat = RESP_TIMEOUT + NRC;
    else               exp_lat = delay + 1 + len + NRC;
    if (rt != 2'd0 && respond)
      exp_resp = (rt == 2'd3) ? bits[127:0] : {90'b0, bits[45:8]};

    @(negedge clk);
    cap0 = cap_n;
    ifc.cmd_index = idx;
    ifc.cmd_arg   = arg;
    ifc.resp_type = rt;
    ifc.cmd_start = 1'b1;
    if (respond) begin
      card_bits  = bits;
      card_len   = len;
      card_delay = delay;
      -> card_ev;
    end
    @(negedge clk);
    ifc.cmd_start = 1'b0;
    check({tag, ".busy_after_start"}, 128'(ifc.busy), 128'd1);

    if (poke) begin
      repeat (10) @(negedge clk);
      ifc.cmd_index = ~idx;
      ifc.cmd_arg   = ~arg;
      ifc.resp_type = 2'd3;
      ifc.cmd_start = 1'b1;
      @(negedge clk);
      ifc.cmd_start = 1'b0;
    end

    seen_oe = 0; released = 0; n = 0; rel_rise = rise_cnt;
    while (!released && n < 4000) begin
      @(negedge clk); n++;
      if (ifc.sd_cmd_oe) seen_oe = 1;
      else if (seen_oe) begin released = 1; rel_rise = rise_cnt; end
    end
    check({tag, ".released"}, 128'(released), 128'd1);
    check({tag, ".frame"}, 128'(cap), 128'(exp_frame));
    check({tag, ".frame_bits"}, 128'(cap_n - cap0), 128'd48);

    got_done = 0; n = 0; to_rise = -1;
    while (!got_done && n < 8000) begin
      if (ifc.timeout && to_rise < 0) to_rise = rise_cnt - rel_rise;
      if (ifc.done) got_done = 1;
      else begin @(negedge clk); n++; end
    end
    check({tag, ".done_seen"}, 128'(got_done), 128'd1);
    check({tag, ".latency"}, 128'(rise_cnt - rel_rise), 128'(exp_lat));
    check({tag, ".busy_at_done"}, 128'(ifc.busy), 128'd1);
    check({tag, ".timeout"}, 128'(ifc.timeout), 128'(exp_to));
    check({tag, ".crc_err"}, 128'(ifc.crc_err), 128'(exp_ce));
    check({tag, ".resp"}, ifc.resp, exp_resp);
    if (exp_to) check({tag, ".timeout_at"}, 128'(to_rise), 128'(RESP_TIMEOUT));
    @(negedge clk);
    check({tag, ".done_pulse"}, 128'(ifc.done), 128'd0);
    check({tag, ".busy_after"}, 128'(ifc.busy), 128'd0);
  endtask

  initial begin
    logic [135:0] bits;
    logic [1:0]   rt;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [127:0] lp;
    bit           respond;
    int           d0, pos;
    time          t1, t2;

    ifc.cmd_start = 1'b0;
    ifc.cmd_index = '0;
    ifc.cmd_arg   = '0;
    ifc.resp_type = '0;
    ifc.sd_cmd_in = 1'b1;

    // Reset state while held.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    // sd_clk period and high time.
    @(posedge ifc.sd_clk); t1 = $time;
    @(negedge ifc.sd_clk); t2 = $time;
    check("sdclk.high", 128'(t2 - t1), 128'(CLK_DIV * 10));
    @(posedge ifc.sd_clk); t2 = $time;
    check("sdclk.period", 128'(t2 - t1), 128'(2 * CLK_DIV * 10));

    // CMD0, no response.
    run_cmd("cmd0", 6'd0, 32'h0, 2'd0, 1'b0, '0, 0, 48'h400000000095, 1'b0);

    // CMD8 with R7 response.
    bits = 136'h08000001AA13;
    run_cmd("cmd8", 6'd8, 32'h000001AA, 2'd1, 1'b1, bits, 3, 48'h48000001AA87, 1'b0);
    check("cmd8.resp_const", ifc.resp, 128'h08000001AA);

    // CMD8 with bit 20 of the response corrupted.
    bits[20] = ~bits[20];
    run_cmd("cmd8_bad", 6'd8, 32'h000001AA, 2'd1, 1'b1, bits, 5, 48'h48000001AA87, 1'b0);
    check("cmd8_bad.crc_const", 128'(ifc.crc_err), 128'(CRC_ON));

    // CMD2 with a long response.
    lp = {$urandom, $urandom, $urandom, $urandom};
    lp[0] = 1'b1;
    bits = {8'h3F, lp};
    run_cmd("cmd2", 6'd2, 32'h0, 2'd3, 1'b1, bits, 1, ref_frame(6'd2, 32'h0), 1'b0);

    // CMD1, card silent.
    run_cmd("cmd1_to", 6'd1, 32'h40FF8000, 2'd2, 1'b0, '0, 0, ref_frame(6'd1, 32'h40FF8000), 1'b0);

    // Reset asserted mid-SEND.
    d0 = done_cnt;
    @(negedge clk);
    ifc.cmd_index = 6'd17; ifc.cmd_arg = 32'h12345678; ifc.resp_type = 2'd1;
    ifc.cmd_start = 1'b1;
    @(negedge clk);
    ifc.cmd_start = 1'b0;
    repeat (60) @(negedge clk);
    check("abort.mid_send_oe", 128'(ifc.sd_cmd_oe), 128'd1);
    rst = 1'b0;
    #1;
    check_idle_outputs("abort");
    exp_resp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (400) @(negedge clk);
    check("abort.no_done", 128'(done_cnt - d0), 128'd0);
    check("abort.busy", 128'(ifc.busy), 128'd0);

    // CMD0 after abort, with a stray cmd_start while busy.
    run_cmd("cmd0_post", 6'd0, 32'h0, 2'd0, 1'b0, '0, 0, 48'h400000000095, 1'b1);
    d0 = done_cnt;
    repeat (200) @(negedge clk);
    check("poke.no_second_txn", 128'(done_cnt - d0), 128'd0);
    check("poke.idle_busy", 128'(ifc.busy), 128'd0);

    // Randomized commands and card behaviour.
    for (int k = 0; k < 10; k++) begin
      rt      = 2'($urandom_range(3, 0));
      idx     = 6'($urandom);
      arg     = $urandom;
      respond = (rt != 2'd0) && ($urandom_range(4, 0) != 0);
      if (rt == 2'd3) begin
        lp = {$urandom, $urandom, $urandom, $urandom};
        lp[0] = 1'b1;
        bits = {8'h3F, lp};
      end else begin
        bits = {88'b0, card_short(6'($urandom), $urandom)};
        if (rt == 2'd2) bits[7:1] = 7'h7F;
      end
      if ($urandom_range(2, 0) == 0) begin
        pos = (rt == 2'd3) ? $urandom_range(134, 0) : $urandom_range(46, 0);
        bits[pos] = ~bits[pos];
      end
      run_cmd($sformatf("rnd%0d", k), idx, arg, rt, respond, bits,
              $urandom_range(20, 0), ref_frame(idx, arg), 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
